ama_riscv_fetch: RTL
====================

Name: ama_riscv_fetch

Overview:
Instruction fetch stage, directly upstream of the decoder. It owns the IF program counter and issues single-outstanding requests to a variable-latency instruction memory (req/gnt, then rvalid). It presents one instruction per accepted response to the ID stage (inst_id, pc_id), injecting NOPs on stall, clear and redirect. It consumes the decoder's pc_sel, pc_we, stall_if and clear_if, plus the EX ALU result used as the redirect target.

Parameters:
START_ADDR, 32'h0000_0000, PC value loaded by reset and by pc_sel = `PC_SEL_START_ADDR
NOP_INST, 32'h0000_0013, instruction (addi x0,x0,0) presented to ID when no valid instruction is present

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
pc_sel  in  2  next-PC select, `PC_SEL_* encodings: INC4, ALU, START_ADDR
pc_we  in  1  PC write enable from decoder
stall_if  in  1  ID is stalled; do not advance ID
clear_if  in  1  flush IF/ID; discard buffered and in-flight instruction
alu_out  in  32  redirect target from EX
imem_req  out  1  request valid
imem_addr  out  32  request byte address, bits [1:0] always 0
imem_gnt  in  1  request accepted this cycle (imem_req & imem_gnt = handshake)
imem_rvalid  in  1  response valid, 1-cycle pulse, 1 or more cycles after grant
imem_rdata  in  32  response instruction
inst_id  out  32  instruction to decoder (registered)
pc_id  out  32  PC of inst_id (registered)
id_valid  out  1  inst_id is a real fetched instruction

Behaviour:
- Reset (async): state=BOOT, pc_if=START_ADDR, drop_r=0, buf_valid=0. Outputs: inst_id=NOP_INST, pc_id=START_ADDR, id_valid=0, imem_req=0.
- States:
  - BOOT: one cycle, then ISSUE.
  - ISSUE: imem_req=1, imem_addr=pc_if. On gnt go to WAIT.
  - WAIT: imem_req=0; wait for rvalid.
  - HOLD: response is buffered, ID is stalled; imem_req=0.
- Response handling in WAIT on rvalid:
  - drop_r=1: discard the data, clear drop_r, go to ISSUE.
  - else, stall_if=0 and clear_if=0: accept.
  - else, stall_if=1: store the data in buf_inst, set buf_valid, go to HOLD.
  - else, clear_if=1: discard, go to ISSUE.
- Accept (from WAIT on rvalid, or from HOLD when stall_if falls):
  - Next cycle: inst_id = instruction, pc_id = pc_if, id_valid = 1.
  - pc_if <= pc_if+4 (mod 2^32, wraps at 32'hFFFF_FFFC to 0).
  - State ISSUE, buf_valid cleared.
- Default ID update: every cycle with no accept, inst_id = NOP_INST and id_valid = 0; pc_id holds. This covers stall, clear and empty cycles, so a stalled ID instruction is replaced by a bubble after one cycle.
- Redirect, when pc_we=1 and pc_sel=ALU or START_ADDR:
  - pc_if <= {alu_out[31:2],2'b00} for ALU, or START_ADDR.
  - Any buffered instruction is discarded.
  - If in WAIT with no rvalid this cycle, set drop_r. An rvalid in the same cycle is dropped directly.
  - Next state ISSUE, or WAIT with drop_r set.
  - Redirect overrides accept in the same cycle; the accepted data is dropped and no +4 is applied.
- clear_if in HOLD: discard the buffer, pc_if unchanged (the instruction is refetched), go to ISSUE.
- Priority when simultaneous: reset > redirect > clear_if > stall_if > accept.
- pc_sel=INC4 with pc_we=1 only permits the +4 advance on accept. pc_we=0 blocks redirects but not response buffering.
- imem_req stays asserted in ISSUE until gnt. A redirect while in ISSUE with no gnt updates imem_addr next cycle; no drop is needed.
- Throughput: at most one instruction per two cycles (ISSUE plus at least one WAIT cycle).

Optional Feature:
AMA_RISCV_FETCH_PERF_EN
- Defined: adds outputs perf_fetch_cnt[31:0] (accepts), perf_drop_cnt[31:0] (dropped or discarded responses) and perf_stall_cnt[31:0] (cycles in HOLD).
- All counters are saturating at 32'hFFFF_FFFF and reset to 0.
- Not defined: ports and logic are absent; core behaviour is identical.

Test Plan:
- Reset release, memory returns rvalid 1 cycle after gnt with data 32'h0010_0093 → first request imem_addr=32'h0, then inst_id=32'h0010_0093, pc_id=0, id_valid=1, then next request at addr 32'h4.
- Response arrives while stall_if=1 for 3 cycles → inst_id=NOP_INST, id_valid=0 during the stall, no imem_req; the held instruction appears the cycle after stall_if falls, followed by a request at pc+4.
- Redirect (pc_we=1, pc_sel=ALU, alu_out=32'h0000_0103) while in WAIT; the stale rvalid arrives 2 cycles later → stale data never reaches ID; the next request has imem_addr=32'h0000_0100.
- clear_if asserted in HOLD → buffer discarded, the same pc_if is re-requested, id_valid=0 for that cycle.
- pc_if=32'hFFFF_FFFC accepted → next imem_addr=32'h0000_0000.
- rst asserted mid-WAIT (async) → imem_req=0, id_valid=0, inst_id=NOP_INST immediately; a later stale rvalid is ignored; the first post-reset request goes to START_ADDR.

Source files
------------

// File: rtl/ama_riscv_fetch.sv
// ama_riscv_fetch: RISC-V instruction fetch stage with single-outstanding imem req/gnt/rvalid interface
//   clk, rst            clock, asynchronous active-high reset
//   pc_sel_i, pc_we_i   next-PC select (`PC_SEL_*) and write enable from decoder
//   stall_if_i          ID stalled, hold fetched instruction
//   clear_if_i          flush buffered and in-flight instruction
//   alu_out_i           redirect target from EX
//   imem_req_o/addr_o   memory request and word-aligned byte address
//   imem_gnt_i          request accepted
//   imem_rvalid_i/rdata_i  response pulse and instruction
//   inst_id_o, pc_id_o, id_valid_o  registered instruction, its PC and validity to ID
//   AMA_RISCV_FETCH_PERF_EN adds perf_fetch_cnt_o, perf_drop_cnt_o, perf_stall_cnt_o
`ifndef PC_SEL_INC4
`define PC_SEL_INC4 2'd0
`endif
`ifndef PC_SEL_ALU
`define PC_SEL_ALU 2'd1
`endif
`ifndef PC_SEL_START_ADDR
`define PC_SEL_START_ADDR 2'd2
`endif

module ama_riscv_fetch #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pc_sel_i,
    input  logic        pc_we_i,
    input  logic        stall_if_i,
    input  logic        clear_if_i,
    input  logic [31:0] alu_out_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_id_o,
    output logic [31:0] pc_id_o,
    output logic        id_valid_o
`ifdef AMA_RISCV_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_drop_cnt_o,
    output logic [31:0] perf_stall_cnt_o
`endif
);

    typedef enum logic [1:0] {BOOT, ISSUE, WAIT, HOLD} state_t;

    state_t state_q, state_d;
    logic [31:0] pc_q, pc_d, buf_inst_q, buf_inst_d, inst_q, inst_d, pc_id_q, pc_id_d, acc_inst;
    logic drop_q, drop_d, buf_valid_q, buf_valid_d, id_valid_q, id_valid_d, redirect, accept;

    assign redirect = pc_we_i && (pc_sel_i == `PC_SEL_ALU || pc_sel_i == `PC_SEL_START_ADDR);

    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        drop_d = drop_q;
        buf_valid_d = buf_valid_q;
        buf_inst_d = buf_inst_q;
        accept = 1'b0;
        acc_inst = imem_rdata_i;
        if (redirect) begin
            pc_d = pc_sel_i == `PC_SEL_ALU ? alu_out_i & ~32'd3 : START_ADDR;
            buf_valid_d = 1'b0;
            // a request already granted to the old PC must have its response thrown away
            drop_d = (state_q == WAIT && !imem_rvalid_i) || (state_q == ISSUE && imem_gnt_i);
            state_d = drop_d ? WAIT : ISSUE;
        end else begin
            case (state_q)
                BOOT: state_d = ISSUE;
                ISSUE: if (imem_gnt_i) state_d = WAIT;
                WAIT: if (imem_rvalid_i) begin
                    if (drop_q || clear_if_i) begin
                        drop_d = 1'b0;
                        state_d = ISSUE;
                    end else if (stall_if_i) begin
                        buf_inst_d = imem_rdata_i;
                        buf_valid_d = 1'b1;
                        state_d = HOLD;
                    end else accept = 1'b1;
                end
                HOLD: if (clear_if_i) begin
                    buf_valid_d = 1'b0;
                    state_d = ISSUE;
                end else if (!stall_if_i && buf_valid_q) begin
                    accept = 1'b1;
                    acc_inst = buf_inst_q;
                end
                default: state_d = BOOT;
            endcase
            if (accept) begin
                pc_d = pc_q + 32'd4;
                buf_valid_d = 1'b0;
                state_d = ISSUE;
            end
        end
        inst_d = accept ? acc_inst : NOP_INST;
        pc_id_d = accept ? pc_q : pc_id_q;
        id_valid_d = accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q <= START_ADDR;
            drop_q <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_inst_q <= NOP_INST;
            inst_q <= NOP_INST;
            pc_id_q <= START_ADDR;
            id_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            drop_q <= drop_d;
            buf_valid_q <= buf_valid_d;
            buf_inst_q <= buf_inst_d;
            inst_q <= inst_d;
            pc_id_q <= pc_id_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign imem_req_o = state_q == ISSUE;
    assign imem_addr_o = pc_q;
    assign inst_id_o = inst_q;
    assign pc_id_o = pc_id_q;
    assign id_valid_o = id_valid_q;

`ifdef AMA_RISCV_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, drop_cnt_q, stall_cnt_q;
    logic drop_ev;

    // responses or buffered instructions that never reach ID
    assign drop_ev = (state_q == WAIT && imem_rvalid_i && (drop_q || redirect || clear_if_i)) ||
                     (state_q == HOLD && (redirect || clear_if_i));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            drop_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + {31'd0, accept && !(&fetch_cnt_q)};
            drop_cnt_q <= drop_cnt_q + {31'd0, drop_ev && !(&drop_cnt_q)};
            stall_cnt_q <= stall_cnt_q + {31'd0, state_q == HOLD && !(&stall_cnt_q)};
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_drop_cnt_o = drop_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule
